plx_local_master: RTL
=====================

Name: plx_local_master

Overview:
- Local-bus initiator for the PLX 9030-style 32-bit local bus. It drives nADS, WnR, nBLAST, nCS2, nCS3, LA and LD, and completes beats on nREADY/nBTERM from a target.
- It executes single or burst commands to three spaces: TIO (no CS), TURF (CS2) and LOS memory (CS3).
- It is used on the bench/emulation FPGA and in loopback tests against the TURFIO target interface.

Parameters:
- LEN_BITS, 4, width of cmd_len_i. A burst is cmd_len_i+1 beats, 1..16 at default.
- TIMEOUT_CYCLES, 255, cycles without nREADY before a transfer aborts. Range 2..65535.

Ports:
- clk_i  in  1  bus/system clock
- rst_n_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high in IDLE; command accepted when cmd_valid_i && cmd_ready_o
- cmd_wr_i  in  1  1 = write, 0 = read
- cmd_space_i  in  2  0 = TIO, 1 = TURF (nCS2), 2 = MEM (nCS3), 3 = treated as 0
- cmd_addr_i  in  11  start dword address, placed on LA[12:2]
- cmd_len_i  in  LEN_BITS  beats minus one
- wr_dat_i  in  32  head of a show-ahead write FIFO
- wr_dat_rd_o  out  1  pop strobe; LD_o loads wr_dat_i in the same cycle
- rd_dat_o  out  32  read data
- rd_valid_o  out  1  one-cycle strobe per read beat
- done_o  out  1  one-cycle pulse at command end
- err_o  out  1  one-cycle pulse with done_o on timeout
- nADS, WnR, nBLAST, nCS2, nCS3  out  1 each  bus strobes
- LA  out  11  bus address [12:2]
- LD_o  out  32  write data; LD_oe  out  1  data output enable (high = drive)
- LD_i  in  32  bus data in
- nREADY  in  1  target ready, active low
- nBTERM  in  1  target burst terminate, active low

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous and active-low; every register clears immediately on assertion.
- Reset values: nADS=nBLAST=nCS2=nCS3=1, WnR=0, LA=0, LD_o=0, LD_oe=0, cmd_ready_o=1, and wr_dat_rd_o, rd_dat_o, rd_valid_o, done_o, err_o all 0.
- Reset mid-transfer releases the bus immediately. No done_o is generated.
- All bus outputs are registered. Inputs are sampled at clk_i edges.
- FSM states: IDLE, ADDR, DATA, TURN.
- IDLE:
  - cmd_ready_o=1.
  - On accept: latch cmd fields, remaining-beat counter = cmd_len_i, go to ADDR.
  - For writes, wr_dat_rd_o=1 in the accept cycle and LD_o <= wr_dat_i.
- ADDR (exactly 1 cycle):
  - nADS=0, LA=current address, WnR=cmd_wr.
  - nCS2=0 only for space 1; nCS3=0 only for space 2.
  - LD_oe=1 for writes, 0 for reads.
  - nBLAST=0 if remaining==0.
  - Next state: DATA.
- DATA:
  - nADS=1. CS, WnR and LD_oe are held. nBLAST=0 iff remaining==0.
  - A beat completes on any cycle with nREADY==0. On completion:
    - Write: if remaining != 0, pulse wr_dat_rd_o and load LD_o.
    - Read: rd_dat_o <= LD_i, rd_valid_o=1 next cycle.
    - LA increments by 1 mod 2^11 (0x7FF wraps to 0x000).
    - remaining decrements.
  - Last beat (remaining==0 at completion): go to TURN, deassert CS/LD_oe/nBLAST, pulse done_o.
  - nREADY==0 && nBTERM==0 on a non-last beat: go to ADDR. A new nADS is issued at the incremented LA with the remaining beats.
  - nBTERM==0 without nREADY==0 is ignored.
- Timeout:
  - The counter clears at ADDR and on every beat completion, and increments in DATA.
  - At TIMEOUT_CYCLES the master releases all strobes, sets LD_oe=0, pulses done_o and err_o together, and goes to TURN.
  - Beats not yet transferred are dropped. Write FIFO words not popped stay in the FIFO.
- TURN (exactly 1 cycle): bus idle, cmd_ready_o=0. This gives the target's registered output enable time to release LD before the next ADS. Next state: IDLE.
- Command throughput: minimum 4 cycles per single-beat command (accept, ADDR, DATA with immediate READY, TURN).
- cmd_* inputs are ignored while cmd_ready_o=0.
- Simultaneous events: nREADY on the timeout cycle counts as a successful completion; timeout is not flagged.

Test Plan:
1. TIO write, addr 0x005, data 0xDEADBEEF, target READY 2 cycles after ADS -> one nADS with LA=0x005, WnR=1, nCS2=nCS3=1, nBLAST=0, LD_o=0xDEADBEEF with LD_oe=1; done_o 1 cycle after READY; err_o=0.
2. MEM burst write, len=3, addr 0x100, READY every cycle -> single nADS, LA 0x100..0x103, nBLAST=0 only on beat 4, 4 wr_dat_rd_o pulses, done_o once.
3. Same burst with nBTERM+nREADY on beat 2 -> second nADS at LA=0x102, 2 further beats, nBLAST=0 on the final beat, 4 pops total.
4. TURF read, addr 0x003, target READY after 5 cycles with LD_i=0x12345678 -> nCS2=0, LD_oe never 1, rd_valid_o single pulse with 0x12345678, cmd_ready_o back high 2 cycles after READY.
5. TIMEOUT_CYCLES=16, no READY -> done_o and err_o pulse 16 cycles into DATA; strobes released; next command runs normally.
6. Burst len=1 at 0x7FF -> LA 0x7FF then 0x000. Separately: assert rst_n_i mid-burst -> all outputs at reset values in the same cycle; no done_o.

Source files
------------

// File: rtl/plx_local_master.sv
// plx_local_master: PLX 9030-style local-bus initiator for single/burst reads and writes to TIO, TURF and LOS memory.
module plx_local_master #(
  parameter int LEN_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_wr_i,
  input  logic [1:0]          cmd_space_i,
  input  logic [10:0]         cmd_addr_i,
  input  logic [LEN_BITS-1:0] cmd_len_i,
  input  logic [31:0]         wr_dat_i,
  output logic                wr_dat_rd_o,
  output logic [31:0]         rd_dat_o,
  output logic                rd_valid_o,
  output logic                done_o,
  output logic                err_o,
  output logic                nADS,
  output logic                WnR,
  output logic                nBLAST,
  output logic                nCS2,
  output logic                nCS3,
  output logic [10:0]         LA,
  output logic [31:0]         LD_o,
  output logic                LD_oe,
  input  logic [31:0]         LD_i,
  input  logic                nREADY,
  input  logic                nBTERM
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, TURN} state_t;
  state_t r_state, w_next;
  logic [LEN_BITS-1:0] r_rem;
  logic [15:0] r_to;
  logic w_accept, w_beat, w_last, w_tout;
  assign cmd_ready_o = r_state == IDLE;
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  assign w_beat      = r_state == DATA && !nREADY;
  assign w_last      = w_beat && r_rem == '0;
  // A beat landing on the final timeout cycle wins over the abort.
  assign w_tout      = r_state == DATA && nREADY && r_to == 16'(TIMEOUT_CYCLES - 1);
  assign wr_dat_rd_o = (w_accept && cmd_wr_i) || (w_beat && WnR && r_rem != '0);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_accept ? ADDR : IDLE;
      ADDR: w_next = DATA;
      DATA: w_next = (w_last || w_tout) ? TURN : (w_beat && !nBTERM) ? ADDR : DATA;
      TURN: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      nADS       <= 1'b1;
      nBLAST     <= 1'b1;
      nCS2       <= 1'b1;
      nCS3       <= 1'b1;
      WnR        <= 1'b0;
      LA         <= '0;
      LD_o       <= '0;
      LD_oe      <= 1'b0;
      rd_dat_o   <= '0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      r_rem      <= '0;
      r_to       <= '0;
    end else begin
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      rd_valid_o <= 1'b0;
      if (wr_dat_rd_o) LD_o <= wr_dat_i;
      if (w_accept) begin
        nADS   <= 1'b0;
        LA     <= cmd_addr_i;
        WnR    <= cmd_wr_i;
        nCS2   <= cmd_space_i != 2'd1;
        nCS3   <= cmd_space_i != 2'd2;
        LD_oe  <= cmd_wr_i;
        nBLAST <= cmd_len_i != '0;
        r_rem  <= cmd_len_i;
      end
      if (r_state == ADDR) begin
        nADS <= 1'b1;
        r_to <= '0;
      end
      if (r_state == DATA) r_to <= r_to + 16'd1;
      if (w_beat) begin
        LA     <= LA + 11'd1;
        r_to   <= '0;
        r_rem  <= r_rem - LEN_BITS'(1);
        nBLAST <= r_rem != LEN_BITS'(1);
        if (!WnR) begin
          rd_dat_o   <= LD_i;
          rd_valid_o <= 1'b1;
        end
        if (!nBTERM && r_rem != '0) nADS <= 1'b0;
      end
      if (w_last || w_tout) begin
        nBLAST <= 1'b1;
        nCS2   <= 1'b1;
        nCS3   <= 1'b1;
        LD_oe  <= 1'b0;
        WnR    <= 1'b0;
        done_o <= 1'b1;
      end
      if (w_tout) err_o <= 1'b1;
    end
  end
endmodule
